// File: rtl/dec_rr_arbiter_pkg.sv
// Shared definitions for the decoder round-robin arbiter: widths, FSM encoding
// and the select-to-one-hot mapping the downstream decoder also implements.
package dec_rr_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    return NREQ'(1) << s;
  endfunction

endpackage

// File: rtl/dec_rr_arbiter_if.sv
// Requester/decoder side bundle of the arbiter: request vector in, decoder
// select/enable plus grant and status flags out.
interface dec_rr_arbiter_if;
  import dec_rr_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic [SEL_W-1:0] sel;
  logic             sel_en;
  logic [NREQ-1:0]  gnt;
  logic             idle;
  logic             preempt;

  modport master (
    input  req,
    output sel,
    output sel_en,
    output gnt,
    output idle,
    output preempt
  );

  modport slave (
    output req,
    input  sel,
    input  sel_en,
    input  gnt,
    input  idle,
    input  preempt
  );

endinterface

// File: rtl/dec_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: rotate requests so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick8
  import dec_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [SEL_W-1:0] src;
      // 3-bit add wraps modulo 8, giving the circular search order
      assign src     = SEL_W'(gi) + ptr;
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign any = |rot;
  assign idx = off + ptr;

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoder: grants one requester at a time,
// bounds each grant by MAX_HOLD and inserts a one-cycle dead gap between owners.
module dec_rr_arbiter
  import dec_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input logic              clk,
  input logic              rst_n,
  dec_rr_arbiter_if.master bus
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic             sel_en_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             idle_reg;
  logic             preempt_reg, preempt_next;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_expire;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req   = bus.req[sel_reg];
  // hold_reg counts completed grant cycles, so expiry is one short of the limit
  assign hold_expire = (MAX_HOLD != 0) && (hold_reg == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    hold_next    = hold_reg;
    preempt_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_GAP: begin
        if (pick_any) begin
          state_next = ST_GRANT;
          sel_next   = pick_idx;
          hold_next  = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_expire) begin
          state_next   = ST_GAP;
          ptr_next     = sel_reg + SEL_W'(1);
          // a release in the expiry cycle is not a preemption
          preempt_next = owner_req;
        end else if (!(&hold_reg)) begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      sel_reg     <= '0;
      hold_reg    <= '0;
      sel_en_reg  <= 1'b0;
      gnt_reg     <= '0;
      idle_reg    <= 1'b1;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      hold_reg    <= hold_next;
      sel_en_reg  <= (state_next == ST_GRANT);
      gnt_reg     <= (state_next == ST_GRANT) ? sel_to_onehot(sel_next) : '0;
      idle_reg    <= (state_next == ST_IDLE);
      preempt_reg <= preempt_next;
    end
  end

  assign bus.sel     = sel_reg;
  assign bus.sel_en  = sel_en_reg;
  assign bus.gnt     = gnt_reg;
  assign bus.idle    = idle_reg;
  assign bus.preempt = preempt_reg;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter: three instances (hold limits 16, 3 and
// unlimited) share one request vector and reset; each scenario checks one.
module tb_dec_rr_arbiter;
  import dec_rr_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  dec_rr_arbiter_if bus_def ();
  dec_rr_arbiter_if bus_h3 ();
  dec_rr_arbiter_if bus_h0 ();

  assign bus_def.req = req;
  assign bus_h3.req  = req;
  assign bus_h0.req  = req;

  dec_rr_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) u_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));
  dec_rr_arbiter #(.MAX_HOLD(3),  .HOLD_W(2)) u_h3  (.clk(clk), .rst_n(rst_n), .bus(bus_h3));
  dec_rr_arbiter #(.MAX_HOLD(0),  .HOLD_W(5)) u_h0  (.clk(clk), .rst_n(rst_n), .bus(bus_h0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // drive req, let one rising edge pass, return on the following falling edge
  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_sel", bus_def.sel, 3'd0);
    check("rst_sel_en", bus_def.sel_en, 1'b0);
    check("rst_gnt", bus_def.gnt, 8'h00);
    check("rst_idle", bus_def.idle, 1'b1);
    check("rst_preempt", bus_def.preempt, 1'b0);
    rst_n = 1'b1;

    // single request, release, gap then idle
    step(8'h04);
    check("single_sel", bus_def.sel, 3'd2);
    check("single_sel_en", bus_def.sel_en, 1'b1);
    check("single_gnt", bus_def.gnt, 8'h04);
    check("single_idle", bus_def.idle, 1'b0);
    step(8'h00);
    check("gap_gnt", bus_def.gnt, 8'h00);
    check("gap_sel_en", bus_def.sel_en, 1'b0);
    check("gap_sel_hold", bus_def.sel, 3'd2);
    check("gap_idle", bus_def.idle, 1'b0);
    step(8'h00);
    check("back_idle", bus_def.idle, 1'b1);

    // full rotation with hold limit 3: 3 grant cycles then a preempt gap
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        step(8'hFF);
        check("rot_gnt", bus_h3.gnt, 8'h01 << (k % 8));
        check("rot_no_pre", bus_h3.preempt, 1'b0);
      end
      step(8'hFF);
      check("rot_gap_gnt", bus_h3.gnt, 8'h00);
      check("rot_gap_pre", bus_h3.preempt, 1'b1);
    end

    // pointer moves past the finished owner
    do_reset();
    step(8'h20);
    check("prio_own5", bus_def.gnt, 8'h20);
    step(8'h01);
    check("prio_gap1", bus_def.gnt, 8'h00);
    step(8'h21);
    check("prio_ptr6_0", bus_def.gnt, 8'h01);
    step(8'h21);
    check("prio_keep0", bus_def.gnt, 8'h01);
    step(8'h20);
    check("prio_gap2", bus_def.gnt, 8'h00);
    check("prio_gap2_pre", bus_def.preempt, 1'b0);
    step(8'h21);
    check("prio_ptr1_5", bus_def.gnt, 8'h20);

    // release in the same cycle as hold expiry
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(8'h08);
      check("tie_gnt", bus_h3.gnt, 8'h08);
    end
    step(8'h00);
    check("tie_gap_gnt", bus_h3.gnt, 8'h00);
    check("tie_pre", bus_h3.preempt, 1'b0);
    check("tie_gap_idle", bus_h3.idle, 1'b0);
    step(8'h02);
    check("tie_next_gnt", bus_h3.gnt, 8'h02);

    // unlimited hold
    do_reset();
    for (int c = 0; c < 100; c++) begin
      step(8'h08);
      check("nolim_gnt", bus_h0.gnt, 8'h08);
      check("nolim_pre", bus_h0.preempt, 1'b0);
    end

    // asynchronous reset mid-grant, with ptr moved away from 0 first
    do_reset();
    step(8'h01);
    check("ar_own0", bus_def.gnt, 8'h01);
    step(8'h10);
    step(8'h10);
    check("ar_own4", bus_def.gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", bus_def.gnt, 8'h00);
    check("ar_sel", bus_def.sel, 3'd0);
    check("ar_sel_en", bus_def.sel_en, 1'b0);
    check("ar_idle", bus_def.idle, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h11);
    check("ar_restart_ptr0", bus_def.gnt, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
